// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter
//   Merges pixel writes from CHANNELS drawer channels (fill, line, symbol, ...)
//   onto the single frame_buffer write port, and sequences buffer swaps so a
//   swap only happens after every queued pixel has reached the frame buffer.
//
//   Each channel has a DEPTH-entry FIFO behind a valid/ready handshake. A
//   round-robin arbiter pops at most one FIFO head per cycle into a registered
//   output stage. When nothing is popped, the address and data outputs are
//   driven to zero so they can still be OR-ed with legacy write sources.
//
// Ports
//   clk              system clock, rising edge
//   rst_n            asynchronous active-low reset
//   ch_valid         per-channel write request
//   ch_ready         per-channel accept (valid & ready at an edge = transfer)
//   ch_addr          packed addresses, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   ch_data          packed data, same packing as ch_addr
//   swap_req         single-cycle buffer swap request
//   swap_ack         single-cycle acknowledge, coincident with fb_swap
//   fb_write_enable  frame_buffer write strobe
//   fb_write_addr    frame_buffer write address
//   fb_write_data    frame_buffer write data
//   fb_swap          frame_buffer swap strobe
//   busy             queued or in-flight work, or a swap in progress
module fb_write_arbiter #(
    parameter int CHANNELS   = 3,
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [CHANNELS-1:0]            ch_valid,
    output logic [CHANNELS-1:0]            ch_ready,
    input  logic [CHANNELS*ADDR_WIDTH-1:0] ch_addr,
    input  logic [CHANNELS*DATA_WIDTH-1:0] ch_data,
    input  logic                           swap_req,
    output logic                           swap_ack,
    output logic                           fb_write_enable,
    output logic [ADDR_WIDTH-1:0]          fb_write_addr,
    output logic [DATA_WIDTH-1:0]          fb_write_data,
    output logic                           fb_swap,
    output logic                           busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int RW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        SWAP  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_WIDTH-1:0] mem_addr [CHANNELS][DEPTH];
    logic [DATA_WIDTH-1:0] mem_data [CHANNELS][DEPTH];
    logic [PW-1:0]         wr_ptr   [CHANNELS];
    logic [PW-1:0]         rd_ptr   [CHANNELS];
    logic [CW-1:0]         count    [CHANNELS];

    logic [CHANNELS-1:0]   push;
    logic [CHANNELS-1:0]   pop;
    logic [CHANNELS-1:0]   not_empty;

    logic [RW-1:0]         rr_ptr;
    logic [RW-1:0]         grant;
    logic [RW-1:0]         rr_next;
    logic                  pop_valid;
    logic [RW:0]           scan_sum;
    logic [RW-1:0]         scan_idx;

    // Per-channel handshake. Ready depends only on registered state (plus the
    // reset pin so nothing is accepted while held in reset); the count used is
    // the pre-edge count, so a full FIFO refuses a write even if it is popped
    // on the same edge.
    always_comb begin
        ch_ready  = '0;
        push      = '0;
        not_empty = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            not_empty[i] = (count[i] != '0);
            ch_ready[i]  = rst_n && (state == RUN) && (count[i] < CW'(DEPTH));
            push[i]      = ch_valid[i] && ch_ready[i];
        end
    end

    // Round-robin scan starting at rr_ptr; the first non-empty FIFO wins.
    always_comb begin
        pop_valid = 1'b0;
        grant     = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            scan_sum = {1'b0, rr_ptr} + (RW+1)'(k);
            if (scan_sum >= (RW+1)'(CHANNELS)) begin
                scan_sum = scan_sum - (RW+1)'(CHANNELS);
            end
            scan_idx = scan_sum[RW-1:0];
            if (!pop_valid && not_empty[scan_idx]) begin
                pop_valid = 1'b1;
                grant     = scan_idx;
            end
        end
    end

    // One-hot pop vector and the pointer that follows the granted channel.
    always_comb begin
        pop = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pop[i] = pop_valid && (grant == RW'(i));
        end
        rr_next = (grant == RW'(CHANNELS - 1)) ? '0 : grant + RW'(1);
    end

    // FIFO bookkeeping. Pointers wrap naturally because DEPTH is a power of
    // two; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PW'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PW'(1);
                end
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + CW'(1);
                    2'b01:   count[i] <= count[i] - CW'(1);
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // FIFO storage needs no reset: the counts decide what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (push[i]) begin
                mem_addr[i][wr_ptr[i]] <= ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                mem_data[i][wr_ptr[i]] <= ch_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Output register and arbitration pointer. Idle cycles drive zeros so the
    // write port stays OR-compatible with legacy sources.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_write_enable <= 1'b0;
            fb_write_addr   <= '0;
            fb_write_data   <= '0;
            rr_ptr          <= '0;
        end else begin
            fb_write_enable <= pop_valid;
            if (pop_valid) begin
                fb_write_addr <= mem_addr[grant][rd_ptr[grant]];
                fb_write_data <= mem_data[grant][rd_ptr[grant]];
                rr_ptr        <= rr_next;
            end else begin
                fb_write_addr <= '0;
                fb_write_data <= '0;
            end
        end
    end

    // Swap sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // DRAIN waits until the last popped write has also left the output
    // register, so the swap never lands on top of a pending pixel.
    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (swap_req) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!(|not_empty) && !fb_write_enable) begin
                    state_next = SWAP;
                end
            end
            SWAP: begin
                state_next = RUN;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    assign fb_swap  = (state == SWAP);
    assign swap_ack = (state == SWAP);
    assign busy     = (|not_empty) || fb_write_enable || (state != RUN);

endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
- Parametrised successor to the wired-OR frame-buffer write path that merges the fill, line and symbol drawers.
- Accepts pixel writes from CHANNELS independent drawer channels through valid/ready handshakes, with a DEPTH-entry FIFO per channel.
- Round-robin arbitration serialises them onto the single frame_buffer write port.
- Sequences swap requests: stalls intake, drains every FIFO, then issues a one-cycle frame_buffer swap.

Parameters:
- CHANNELS, 3: number of drawer channels (1..8).
- ADDR_WIDTH, 19: frame-buffer address width (clog2(640*480)).
- DATA_WIDTH, 1: pixel data width.
- DEPTH, 2: entries per channel FIFO; power of two, at least 2.

Ports:
- clk  in  1: system clock; all state updates on the rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- ch_valid  in  CHANNELS: per-channel write request.
- ch_ready  out  CHANNELS: per-channel accept; a write transfers when valid and ready are both high at a clock edge.
- ch_addr  in  CHANNELS*ADDR_WIDTH: packed addresses; channel i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- ch_data  in  CHANNELS*DATA_WIDTH: packed data, packed the same way as ch_addr.
- swap_req  in  1: single-cycle request to swap buffers.
- swap_ack  out  1: single-cycle pulse, coincident with fb_swap.
- fb_write_enable  out  1: frame_buffer write strobe.
- fb_write_addr  out  ADDR_WIDTH: frame_buffer write address.
- fb_write_data  out  DATA_WIDTH: frame_buffer write data.
- fb_swap  out  1: frame_buffer swap strobe.
- busy  out  1: high when any FIFO is non-empty, an output write is pending, or the state is not RUN.

Behaviour:
- Reset (async, rst_n low):
  - All FIFOs emptied; state RUN; round-robin pointer 0.
  - fb_write_enable, fb_swap, swap_ack and busy are 0; fb_write_addr and fb_write_data are 0.
  - ch_ready is 0 while rst_n is low.
  - Asserting reset mid-drain or mid-write discards all queued writes; no swap is issued.
- ch_ready[i]:
  - Equals (count[i] < DEPTH) && state == RUN.
  - Registered or derived from registered state only; no combinational path from ch_valid or swap_req.
  - A full FIFO does not accept a write, even when a pop happens on the same edge.
- Arbitration:
  - Each cycle, the arbiter scans channels starting at the pointer, wrapping modulo CHANNELS.
  - The first channel with a non-empty FIFO is granted and its head is popped.
  - The pointer then becomes (granted + 1) mod CHANNELS. If no channel is non-empty, the pointer holds.
  - At most one pop per cycle.
- Output register:
  - A popped entry drives fb_write_enable=1 with its addr/data during the cycle following the pop edge.
  - With no pop, fb_write_enable=0 and addr/data are driven to 0, so the outputs stay OR-compatible with legacy sources.
- Latency, empty FIFO, no contention: accepted on edge k, popped on edge k+1, fb_write_enable high in the cycle after edge k+1.
- Throughput: one write per cycle aggregate. A single channel streaming alone sustains one write per cycle when DEPTH is at least 2.
- Ordering: writes within one channel retain FIFO order. There is no ordering guarantee across channels.
- Simultaneous push and pop on the same channel: count is unchanged and both operations take effect.
- State machine:
  - RUN: normal intake. swap_req=1 moves to DRAIN.
  - DRAIN: all ch_ready are 0 and arbitration continues. When all FIFOs are empty and fb_write_enable is 0, move to SWAP.
  - SWAP: fb_swap=1 and swap_ack=1 for exactly one cycle; fb_write_enable is 0. Next state is RUN.
- swap_req is ignored in DRAIN and SWAP; it is not queued.
- swap_req in RUN with everything empty: DRAIN for 1 cycle, then SWAP. fb_swap is high 2 cycles after the swap_req edge.
- Counters are clog2(DEPTH)+1 bits. FIFO read and write pointers wrap modulo DEPTH.

Test Plan:
- Reset and idle:
  - Stimulus: rst_n low for 3 cycles, then released; no valid.
  - Required: all outputs 0; ch_ready=3'b111 from the first cycle after release; busy=0.
- Single write:
  - Stimulus: ch1 writes addr=19'd1234, data=1.
  - Required: exactly one fb_write_enable pulse, with addr=1234 and data=1, 2 edges after the accept.
- Round-robin:
  - Stimulus: all three channels hold valid continuously; ch0 sends addr 0,3,6; ch1 sends 1,4,7; ch2 sends 2,5,8.
  - Required: output sequence 0,1,2,3,4,5,6,7,8 with no gaps once streaming.
- Backpressure:
  - Stimulus: DEPTH=2; ch0 pushes 3 writes on back-to-back edges while ch1 and ch2 stream.
  - Required: ch_ready[0] drops when count hits 2; no write is lost or duplicated; per-channel order is preserved.
- Swap during traffic:
  - Stimulus: queue 5 writes, then pulse swap_req.
  - Required: ch_ready=0 immediately; all 5 writes emitted; then a single fb_swap/swap_ack pulse with fb_write_enable=0 in that cycle; ch_ready returns next cycle. A second swap_req during DRAIN produces no extra pulse.
- Reset mid-drain:
  - Stimulus: 4 writes queued, swap_req, then rst_n low before fb_swap.
  - Required: no fb_swap; no further fb_write_enable after reset; state RUN after release.
